// File: rtl/dmem_access_ctrl.sv
// Byte-serial data memory controller: arbitrates two requesters and sequences
// little-endian byte/word loads and stores through a single-byte memory port.
module dmem_access_ctrl #(
    parameter int unsigned MEM_BYTES = 32,
    parameter int unsigned MEM_AW    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic              req0_word,
    input  logic [31:0]       req0_addr,
    input  logic [31:0]       req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic              req1_word,
    input  logic [31:0]       req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_TAIL  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        r_state;
    logic              r_last_grant;
    logic              r_gnt;
    logic              r_write;
    logic              r_word;
    logic              r_err;
    logic [1:0]        r_k;
    logic              r_cap_pend;
    logic [1:0]        r_cap_k;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [MEM_AW-1:0] r_mem_addr;

    logic              w_idle;
    logic              w_issue;
    logic              w_resp;
    logic              w_grant;
    logic              w_accept;
    logic              w_write;
    logic              w_word;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic [32:0]       w_end;
    logic              w_err;
    logic [1:0]        w_last_k;

    always_comb begin
        w_idle  = (r_state == S_IDLE);
        w_issue = (r_state == S_ISSUE);
        w_resp  = (r_state == S_RESP);

        // On a tie the port that was not served last wins.
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end

        req0_ready = w_idle && req0_valid && !w_grant;
        req1_ready = w_idle && req1_valid && w_grant;
        w_accept   = req0_ready || req1_ready;

        w_write = w_grant ? req1_write : req0_write;
        w_word  = w_grant ? req1_word  : req0_word;
        w_addr  = w_grant ? req1_addr  : req0_addr;
        w_wdata = w_grant ? req1_wdata : req0_wdata;

        // Last byte touched, computed one bit wider so it cannot wrap.
        w_end    = {1'b0, w_addr} + (w_word ? 33'd3 : 33'd0);
        w_err    = (w_end >= 33'(MEM_BYTES));
        w_last_k = r_word ? 2'd3 : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_write      <= 1'b0;
            r_word       <= 1'b0;
            r_err        <= 1'b0;
            r_k          <= 2'd0;
            r_cap_pend   <= 1'b0;
            r_cap_k      <= 2'd0;
            r_wdata      <= 32'd0;
            r_rdata      <= 32'd0;
            r_mem_addr   <= '0;
        end else begin
            // Synchronous memory: the byte read in this cycle lands next cycle.
            r_cap_pend <= w_issue && !r_write;
            r_cap_k    <= r_k;
            if (r_cap_pend) begin
                r_rdata[{r_cap_k, 3'b000} +: 8] <= mem_rdata;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_gnt        <= w_grant;
                        r_last_grant <= w_grant;
                        r_write      <= w_write;
                        r_word       <= w_word;
                        r_wdata      <= w_wdata;
                        r_err        <= w_err;
                        r_rdata      <= 32'd0;
                        r_k          <= 2'd0;
                        if (w_err) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state    <= S_ISSUE;
                            r_mem_addr <= w_addr[MEM_AW-1:0];
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_k == w_last_k) begin
                        r_state <= r_write ? S_RESP : S_TAIL;
                    end else begin
                        r_k        <= r_k + 2'd1;
                        r_mem_addr <= r_mem_addr + 1'b1;
                    end
                end
                S_TAIL:  r_state <= S_RESP;
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr   = r_mem_addr;
        mem_we     = w_issue && r_write;
        mem_re     = w_issue && !r_write;
        mem_wdata  = mem_we ? r_wdata[{r_k, 3'b000} +: 8] : 8'h00;
        req0_done  = w_resp && !r_gnt;
        req1_done  = w_resp && r_gnt;
        resp_rdata = w_resp ? r_rdata : 32'd0;
        resp_err   = w_resp && r_err;
        busy       = !w_idle;
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-array reference model, directed and random
// transactions with cycle-accurate checks of the memory port and responses.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req0_write = 1'b0, req0_word = 1'b0;
    logic [31:0] req0_addr = 32'd0, req0_wdata = 32'd0;
    logic        req1_valid = 1'b0, req1_write = 1'b0, req1_word = 1'b0;
    logic [31:0] req1_addr = 32'd0, req1_wdata = 32'd0;
    logic        req0_ready, req0_done, req1_ready, req1_done;
    logic [31:0] resp_rdata;
    logic        resp_err, busy, mem_we, mem_re;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    bit exp_last = 1'b1;

    // Memory array seen by the DUT, plus a preload path used during reset.
    logic [7:0] mem [32];
    logic [7:0] rd_q = 8'h00;
    logic       pre_we = 1'b0;
    logic [4:0] pre_addr = 5'd0;
    logic [7:0] pre_data = 8'h00;
    logic [7:0] ref_mem [32];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) rd_q <= mem[mem_addr];
    end
    assign mem_rdata = rd_q;

    dmem_access_ctrl #(.MEM_BYTES(32), .MEM_AW(5)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_word(req0_word),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_word(req1_word),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .req1_done(req1_done),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_last = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
        chk({tag, "_done"}, {30'd0, req1_done, req0_done}, 32'd0);
        chk({tag, "_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_misc"}, {28'd0, resp_err, busy, mem_we, mem_re}, 32'd0);
        chk({tag, "_maddr"}, {27'd0, mem_addr}, 32'd0);
        chk({tag, "_mwdata"}, {24'd0, mem_wdata}, 32'd0);
    endtask

    // One isolated transaction on one port, checked cycle by cycle.
    task automatic do_op(input bit port, input bit wr, input bit wd,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        int          lat;
        int          w;
        bit          err;
        bit          act;
        logic [63:0] endp;
        logic [31:0] exp_rd;
        n    = wd ? 4 : 1;
        endp = {32'd0, addr} + 64'(n - 1);
        err  = (endp >= 64'd32);
        lat  = err ? 1 : (wr ? n + 1 : n + 2);
        exp_rd = 32'd0;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                if (wr) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
                else exp_rd[8*i +: 8] = ref_mem[int'(addr) + i];
            end
        end
        if (port) begin
            req1_valid = 1'b1; req1_write = wr; req1_word = wd;
            req1_addr = addr; req1_wdata = wdata; req0_valid = 1'b0;
        end else begin
            req0_valid = 1'b1; req0_write = wr; req0_word = wd;
            req0_addr = addr; req0_wdata = wdata; req1_valid = 1'b0;
        end
        #1;
        w = 0;
        while (!(port ? req1_ready : req0_ready) && w < 20) begin
            cyc();
            #1;
            w++;
        end
        chk("ready", {31'd0, port ? req1_ready : req0_ready}, 32'd1);
        chk("ready_other", {31'd0, port ? req0_ready : req1_ready}, 32'd0);
        exp_last = port;
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            #1;
            act = !err && (c <= n);
            chk("mem_we", {31'd0, mem_we}, {31'd0, act && wr});
            chk("mem_re", {31'd0, mem_re}, {31'd0, act && !wr});
            if (act) chk("mem_addr", {27'd0, mem_addr}, (addr + 32'(c - 1)) & 32'd31);
            if (act && wr) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, wdata[8*(c-1) +: 8]});
            chk("busy", {31'd0, busy}, 32'd1);
            chk("done", {31'd0, port ? req1_done : req0_done}, {31'd0, c == lat});
            chk("done_other", {31'd0, port ? req0_done : req1_done}, 32'd0);
            if (c == lat) begin
                chk("resp_rdata", resp_rdata, exp_rd);
                chk("resp_err", {31'd0, resp_err}, {31'd0, err});
            end
            cyc();
        end
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    // Both ports keep a byte store pending every cycle; grants must alternate.
    task automatic arb_test();
        int i0 = 0;
        int i1 = 0;
        bit g;
        for (int s = 0; s < 8; s++) begin
            req0_valid = (i0 < 4); req0_write = 1'b1; req0_word = 1'b0;
            req0_addr = 32'(16 + i0); req0_wdata = 32'(8'hA0 + i0);
            req1_valid = (i1 < 4); req1_write = 1'b1; req1_word = 1'b0;
            req1_addr = 32'(20 + i1); req1_wdata = 32'(8'hB0 + i1);
            #1;
            if (req0_valid && req1_valid) g = ~exp_last;
            else g = req1_valid;
            chk("arb_ready0", {31'd0, req0_ready}, {31'd0, g == 1'b0});
            chk("arb_ready1", {31'd0, req1_ready}, {31'd0, g == 1'b1});
            exp_last = g;
            if (g) begin ref_mem[20 + i1] = 8'(8'hB0 + i1); i1++; end
            else begin ref_mem[16 + i0] = 8'(8'hA0 + i0); i0++; end
            cyc();
            req0_valid = (i0 < 4); req0_addr = 32'(16 + i0); req0_wdata = 32'(8'hA0 + i0);
            req1_valid = (i1 < 4); req1_addr = 32'(20 + i1); req1_wdata = 32'(8'hB0 + i1);
            for (int c = 1; c <= 2; c++) begin
                #1;
                chk("arb_noready", {30'd0, req1_ready, req0_ready}, 32'd0);
                chk("arb_we", {31'd0, mem_we}, {31'd0, c == 1});
                chk("arb_done", {31'd0, g ? req1_done : req0_done}, {31'd0, c == 2});
                chk("arb_done_other", {31'd0, g ? req0_done : req1_done}, 32'd0);
                cyc();
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        // Preload memory (and the model) with random contents while in reset.
        cyc();
        for (int a = 0; a < 32; a++) begin
            ref_mem[a] = 8'($urandom);
            pre_we = 1'b1; pre_addr = 5'(a); pre_data = ref_mem[a];
            cyc();
        end
        pre_we = 1'b0;
        chk_all_zero("rst");
        reset = 1'b0;
        cyc();
        chk_all_zero("post_rst");

        do_op(1'b0, 1'b1, 1'b1, 32'd4, 32'hDEADBEEF);
        do_op(1'b0, 1'b0, 1'b1, 32'd4, 32'd0);
        do_op(1'b0, 1'b0, 1'b0, 32'd6, 32'd0);

        do_reset();
        arb_test();
        do_op(1'b0, 1'b0, 1'b1, 32'd16, 32'd0);
        do_op(1'b1, 1'b0, 1'b1, 32'd20, 32'd0);

        do_op(1'b1, 1'b0, 1'b1, 32'd29, 32'd0);
        do_op(1'b1, 1'b0, 1'b0, 32'd31, 32'd0);
        do_op(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h12345678);
        do_op(1'b0, 1'b1, 1'b1, 32'd28, 32'hCAFEF00D);
        do_op(1'b1, 1'b0, 1'b1, 32'd27, 32'd0);

        // Reset during the third cycle of a word store to address 8.
        req0_valid = 1'b1; req0_write = 1'b1; req0_word = 1'b1;
        req0_addr = 32'd8; req0_wdata = 32'h11223344;
        #1;
        chk("mr_ready", {31'd0, req0_ready}, 32'd1);
        cyc();
        req0_valid = 1'b0;
        #1;
        chk("mr_we1", {26'd0, mem_we, mem_addr}, {26'd0, 1'b1, 5'd8});
        cyc();
        reset = 1'b1;
        #1;
        chk("mr_we2", {26'd0, mem_we, mem_addr}, {26'd0, 1'b1, 5'd9});
        cyc();
        reset = 1'b0;
        ref_mem[8] = 8'h44;
        ref_mem[9] = 8'h33;
        exp_last = 1'b1;
        chk_all_zero("mr_after");
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("mr_quiet", {28'd0, mem_we, mem_re, req1_done, req0_done}, 32'd0);
        end
        do_op(1'b1, 1'b0, 1'b1, 32'd8, 32'd0);

        for (int t = 0; t < 40; t++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 33)), $urandom);
        end
        for (int a = 0; a < 32; a += 4) begin
            do_op(1'b0, 1'b0, 1'b1, 32'(a), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
